// File: rtl/biquad_pkg.sv
// -----------------------------------------------------------------------------
// biquad_pkg
// Shared definitions for the time-multiplexed biquad cascade:
//   - state_t       : sequencer states (IDLE, ISSUE, DRAIN, WB)
//   - TAP_B0..TAP_A2: tap order within one section, TAPS_PER_SECT = 5
//   - DRAIN_LAST    : final count of the two-cycle pipeline drain
//   - sat_shift()   : arithmetic right shift by the coefficient scaling, then
//                     saturation to a signed data width, with an overflow bit
// -----------------------------------------------------------------------------
package biquad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_WB    = 2'd3
    } state_t;

    localparam int TAPS_PER_SECT = 5;

    localparam logic [2:0] TAP_B0 = 3'd0;
    localparam logic [2:0] TAP_B1 = 3'd1;
    localparam logic [2:0] TAP_B2 = 3'd2;
    localparam logic [2:0] TAP_A1 = 3'd3;
    localparam logic [2:0] TAP_A2 = 3'd4;

    // Two drain cycles: counts 0 and 1
    localparam logic [2:0] DRAIN_LAST = 3'd1;

    typedef struct packed {
        logic [63:0] value;   // saturated result, sign-extended to 64 bits
        logic        ovf;     // result had to be clamped
    } sat_t;

    // Shift the accumulator down by the fractional bits (floor) and clamp the
    // result into the signed range of width_d bits.
    function automatic sat_t sat_shift(input logic signed [63:0] acc,
                                       input int                 scaling,
                                       input int                 width_d);
        sat_t              res;
        logic signed [63:0] shifted;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        shifted = acc >>> scaling;
        max_v   = (64'sd1 <<< (width_d - 1)) - 64'sd1;
        min_v   = -max_v - 64'sd1;
        if (shifted > max_v) begin
            res.value = max_v;
            res.ovf   = 1'b1;
        end else if (shifted < min_v) begin
            res.value = min_v;
            res.ovf   = 1'b1;
        end else begin
            res.value = shifted;
            res.ovf   = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/biquad_mac.sv
// -----------------------------------------------------------------------------
// biquad_mac
// Shared multiply-accumulate for the biquad cascade, shaped for one DSP48:
// registered multiplier inputs -> product register -> accumulator.
// Control travels down the pipe alongside the operands, so a tap issued in
// cycle t lands in the accumulator at the end of cycle t+2.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   issue_valid   : operands below carry a real tap this cycle
//   issue_first   : first tap of a section (accumulator is reloaded)
//   issue_sub     : product is subtracted (feedback taps a1, a2)
//   op_data       : signed data operand (WIDTH_D)
//   op_coeff      : signed coefficient operand (WIDTH_C)
//   acc           : signed accumulator (WIDTH_D+WIDTH_C+3)
// -----------------------------------------------------------------------------
module biquad_mac #(
    parameter int WIDTH_D = 18,
    parameter int WIDTH_C = 18
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 issue_valid,
    input  logic                                 issue_first,
    input  logic                                 issue_sub,
    input  logic signed [WIDTH_D-1:0]            op_data,
    input  logic signed [WIDTH_C-1:0]            op_coeff,
    output logic signed [WIDTH_D+WIDTH_C+2:0]    acc
);

    localparam int PW = WIDTH_D + WIDTH_C;
    localparam int AW = PW + 3;

    logic signed [WIDTH_D-1:0] a_r;
    logic signed [WIDTH_C-1:0] b_r;
    logic                      v1_r, f1_r, s1_r;
    logic signed [PW-1:0]      p_r;
    logic                      v2_r, f2_r, s2_r;
    logic signed [AW-1:0]      acc_r;
    logic signed [AW-1:0]      p_ext_s;

    assign p_ext_s = AW'(p_r);
    assign acc     = acc_r;

    // Multiplier input stage, product stage and accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r   <= {WIDTH_D{1'b0}};
            b_r   <= {WIDTH_C{1'b0}};
            v1_r  <= 1'b0;
            f1_r  <= 1'b0;
            s1_r  <= 1'b0;
            p_r   <= {PW{1'b0}};
            v2_r  <= 1'b0;
            f2_r  <= 1'b0;
            s2_r  <= 1'b0;
            acc_r <= {AW{1'b0}};
        end else begin
            a_r  <= op_data;
            b_r  <= op_coeff;
            v1_r <= issue_valid;
            f1_r <= issue_first;
            s1_r <= issue_sub;
            p_r  <= PW'(a_r) * PW'(b_r);
            v2_r <= v1_r;
            f2_r <= f1_r;
            s2_r <= s1_r;
            if (v2_r) begin
                if (f2_r) begin
                    acc_r <= s2_r ? -p_ext_s : p_ext_s;
                end else begin
                    acc_r <= s2_r ? (acc_r - p_ext_s) : (acc_r + p_ext_s);
                end
            end
        end
    end

endmodule

// File: rtl/biquad_cascade_tdm.sv
// -----------------------------------------------------------------------------
// biquad_cascade_tdm
// NUM_SECT Direct Form I biquads in cascade, time-multiplexed over NUM_CH
// channels on a single multiply-accumulate. Each section takes 8 cycles:
// 5 tap issues (b0 b1 b2 a1 a2), 2 pipeline drain cycles, 1 write-back.
//   y = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2, saturated to WIDTH_D bits.
// Optional build macro BIQUAD_CASCADE_ROUND_EN: round half up before the
// shift instead of truncating toward negative infinity.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   inStrobe        : sample offered; taken when inStrobe && inReady
//   inChannel       : channel of offered sample (>= NUM_CH is refused)
//   dataIn          : signed input sample
//   inReady         : engine idle
//   clrState        : zero all histories (idle only, before a same-cycle accept)
//   coeffWrEn       : coefficient write (idle only)
//   coeffAddr       : sect*5 + tap (0=b0 1=b1 2=b2 3=a1 4=a2)
//   coeffData       : signed coefficient, 1.0 = 2^SCALING
//   outStrobe       : one-cycle strobe with a new result
//   outChannel      : channel of dataOut
//   dataOut         : signed result, held between strobes
//   ovf             : sticky saturation flag, cleared by rst only
// -----------------------------------------------------------------------------
module biquad_cascade_tdm
    import biquad_pkg::*;
#(
    parameter int WIDTH_D  = 18,
    parameter int WIDTH_C  = 18,
    parameter int SCALING  = 16,
    parameter int NUM_SECT = 2,
    parameter int NUM_CH   = 1
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               inStrobe,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]     inChannel,
    input  logic [WIDTH_D-1:0]                                 dataIn,
    output logic                                               inReady,
    input  logic                                               clrState,
    input  logic                                               coeffWrEn,
    input  logic [$clog2(5*NUM_SECT)-1:0]                      coeffAddr,
    input  logic [WIDTH_C-1:0]                                 coeffData,
    output logic                                               outStrobe,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]     outChannel,
    output logic [WIDTH_D-1:0]                                 dataOut,
    output logic                                               ovf
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SW    = (NUM_SECT > 1) ? $clog2(NUM_SECT) : 1;
    localparam int NCOEF = TAPS_PER_SECT * NUM_SECT;
    localparam int CA_W  = $clog2(NCOEF);
    localparam int AW    = WIDTH_D + WIDTH_C + 3;

    state_t state_r, state_s;

    logic [2:0]                cnt_r;
    logic [SW-1:0]             sect_r;
    logic [CH_W-1:0]           ch_r;
    logic signed [WIDTH_D-1:0] x_cur_r;     // input of the section in flight

    logic signed [WIDTH_C-1:0] coeff_r [NCOEF];
    logic signed [WIDTH_D-1:0] x1_r [NUM_CH][NUM_SECT];
    logic signed [WIDTH_D-1:0] x2_r [NUM_CH][NUM_SECT];
    logic signed [WIDTH_D-1:0] y1_r [NUM_CH][NUM_SECT];
    logic signed [WIDTH_D-1:0] y2_r [NUM_CH][NUM_SECT];

    logic                      in_ready_r;
    logic                      out_strobe_r;
    logic [CH_W-1:0]           out_channel_r;
    logic [WIDTH_D-1:0]        data_out_r;
    logic                      ovf_r;

    logic                      ch_ok_s;
    logic                      addr_ok_s;
    logic                      accept_s;
    logic                      last_sect_s;
    logic [CA_W-1:0]           coeff_idx_s;
    logic signed [WIDTH_D-1:0] op_data_s;
    logic signed [WIDTH_C-1:0] op_coeff_s;
    logic                      issue_valid_s;
    logic                      issue_first_s;
    logic                      issue_sub_s;
    logic signed [AW-1:0]      acc_s;
    logic signed [63:0]        acc_wide_s;
    sat_t                      sat_res_s;
    logic signed [WIDTH_D-1:0] y_sat_s;
    logic                      y_ovf_s;

    assign inReady    = in_ready_r;
    assign outStrobe  = out_strobe_r;
    assign outChannel = out_channel_r;
    assign dataOut    = data_out_r;
    assign ovf        = ovf_r;

    assign ch_ok_s     = (32'(inChannel) < NUM_CH);
    assign addr_ok_s   = (32'(coeffAddr) < NCOEF);
    assign accept_s    = (state_r == ST_IDLE) && inStrobe && ch_ok_s;
    assign last_sect_s = (sect_r == SW'(NUM_SECT - 1));
    assign coeff_idx_s = CA_W'(32'(sect_r) * TAPS_PER_SECT + 32'(cnt_r));

    // Operand selection for the tap being issued this cycle
    always_comb begin
        op_data_s     = {WIDTH_D{1'b0}};
        op_coeff_s    = coeff_r[coeff_idx_s];
        issue_valid_s = (state_r == ST_ISSUE);
        issue_first_s = 1'b0;
        issue_sub_s   = 1'b0;
        case (cnt_r)
            TAP_B0: op_data_s = x_cur_r;
            TAP_B1: op_data_s = x1_r[ch_r][sect_r];
            TAP_B2: op_data_s = x2_r[ch_r][sect_r];
            TAP_A1: op_data_s = y1_r[ch_r][sect_r];
            TAP_A2: op_data_s = y2_r[ch_r][sect_r];
            default: op_data_s = {WIDTH_D{1'b0}};
        endcase
        if (issue_valid_s) begin
            issue_first_s = (cnt_r == TAP_B0);
            issue_sub_s   = (cnt_r == TAP_A1) || (cnt_r == TAP_A2);
        end else begin
            issue_first_s = 1'b0;
            issue_sub_s   = 1'b0;
        end
    end

    biquad_mac #(
        .WIDTH_D (WIDTH_D),
        .WIDTH_C (WIDTH_C)
    ) u_mac (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid_s),
        .issue_first (issue_first_s),
        .issue_sub   (issue_sub_s),
        .op_data     (op_data_s),
        .op_coeff    (op_coeff_s),
        .acc         (acc_s)
    );

    // Section result: optional rounding offset, shift by SCALING, clamp
    always_comb begin
`ifdef BIQUAD_CASCADE_ROUND_EN
        acc_wide_s = 64'(acc_s) + (64'sd1 <<< (SCALING - 1));
`else
        acc_wide_s = 64'(acc_s);
`endif
        sat_res_s = sat_shift(acc_wide_s, SCALING, WIDTH_D);
        y_sat_s   = WIDTH_D'(sat_res_s.value);
        y_ovf_s   = sat_res_s.ovf;
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Sequencer next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (cnt_r == TAP_A2) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (cnt_r == DRAIN_LAST) begin
                    state_s = ST_WB;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_WB: begin
                if (last_sect_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Counters, sample latch, section write-back and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r         <= 3'd0;
            sect_r        <= {SW{1'b0}};
            ch_r          <= {CH_W{1'b0}};
            x_cur_r       <= {WIDTH_D{1'b0}};
            in_ready_r    <= 1'b1;
            out_strobe_r  <= 1'b0;
            out_channel_r <= {CH_W{1'b0}};
            data_out_r    <= {WIDTH_D{1'b0}};
            ovf_r         <= 1'b0;
        end else begin
            out_strobe_r <= 1'b0;
            in_ready_r   <= (state_s == ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        ch_r    <= inChannel;
                        x_cur_r <= dataIn;
                        sect_r  <= {SW{1'b0}};
                        cnt_r   <= 3'd0;
                    end
                end
                ST_ISSUE: begin
                    cnt_r <= (cnt_r == TAP_A2) ? 3'd0 : (cnt_r + 3'd1);
                end
                ST_DRAIN: begin
                    cnt_r <= (cnt_r == DRAIN_LAST) ? 3'd0 : (cnt_r + 3'd1);
                end
                ST_WB: begin
                    cnt_r   <= 3'd0;
                    x_cur_r <= y_sat_s;      // feeds the next section
                    if (y_ovf_s) begin
                        ovf_r <= 1'b1;
                    end
                    if (last_sect_s) begin
                        sect_r        <= {SW{1'b0}};
                        out_strobe_r  <= 1'b1;
                        data_out_r    <= y_sat_s;
                        out_channel_r <= ch_r;
                    end else begin
                        sect_r <= sect_r + SW'(1);
                    end
                end
                default: cnt_r <= 3'd0;
            endcase
        end
    end

    // Per-channel, per-section histories: idle clear or write-back shift
    always_ff @(posedge clk) begin
        if (rst || ((state_r == ST_IDLE) && clrState)) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int s = 0; s < NUM_SECT; s++) begin
                    x1_r[c][s] <= {WIDTH_D{1'b0}};
                    x2_r[c][s] <= {WIDTH_D{1'b0}};
                    y1_r[c][s] <= {WIDTH_D{1'b0}};
                    y2_r[c][s] <= {WIDTH_D{1'b0}};
                end
            end
        end else if (state_r == ST_WB) begin
            x2_r[ch_r][sect_r] <= x1_r[ch_r][sect_r];
            x1_r[ch_r][sect_r] <= x_cur_r;
            y2_r[ch_r][sect_r] <= y1_r[ch_r][sect_r];
            y1_r[ch_r][sect_r] <= y_sat_s;
        end
    end

    // Coefficient store; writes land only while idle and in range
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCOEF; i++) begin
                coeff_r[i] <= {WIDTH_C{1'b0}};
            end
        end else if ((state_r == ST_IDLE) && coeffWrEn && addr_ok_s) begin
            coeff_r[coeffAddr] <= coeffData;
        end
    end

endmodule
